line_draw_arbiter: RTL and testbench

LINE_DRAW_ARBITER -- requirements
Module: line_draw_arbiter

---
 rtl/line_pkg.sv | 30 +++
 rtl/rr_arb2.sv | 26 ++
 rtl/line_draw_arbiter.sv | 132 +++++++++++++
 tb/tb_line_draw_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_pkg.sv
// ============================================================================
// line_pkg -- shared types and field widths for the line-draw arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package line_pkg;

   localparam int X_W = 9;
   localparam int Y_W = 8;
   localparam int C_W = 3;

   // Field order fixes the packed layout: colour is the MSB group, x0 the LSB.
   typedef struct packed {
      logic [C_W-1:0] colour;
      logic [Y_W-1:0] y1;
      logic [X_W-1:0] x1;
      logic [Y_W-1:0] y0;
      logic [X_W-1:0] x0;
   } line_cmd_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GO      = 2'd1,
      RELEASE = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// rr_arb2 -- two-requester round-robin decision (pointer names the favoured one)
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arb2 (
   input  logic [1:0] i_req,
   input  logic       i_ptr,
   output logic       o_winner,
   output logic       o_valid
);

   always_comb begin
      o_valid  = |i_req;
      o_winner = 1'b0;
      if (i_req == 2'b11) begin
         o_winner = i_ptr;
      end else begin
         o_winner = i_req[1];
      end
   end

endmodule

`default_nettype wire

// File: rtl/line_draw_arbiter.sv
// ============================================================================
// line_draw_arbiter -- grants one of two requesters to a line-draw engine,
// holds the command while go is high, with a per-draw watchdog.
// Rev 1.0
// ============================================================================
`default_nettype none

module line_draw_arbiter
   import line_pkg::*;
#(
   parameter int MAX_DRAW_CYCLES = 200000
) (
   input  logic             clock,
   input  logic             i_reset_n,
   input  logic [1:0]       i_req,
   input  line_cmd_t        i_cmd0,
   input  line_cmd_t        i_cmd1,
   output logic [1:0]       o_ack,
   output logic             o_grant_id,
   output logic             o_busy,
   output logic             o_go,
   input  logic             i_done,
   output logic [C_W-1:0]   o_colour,
   output logic [X_W-1:0]   o_X0,
   output logic [Y_W-1:0]   o_Y0,
   output logic [X_W-1:0]   o_X1,
   output logic [Y_W-1:0]   o_Y1,
   output logic             o_timeout
);

   localparam int               CNT_W      = (MAX_DRAW_CYCLES > 1) ? $clog2(MAX_DRAW_CYCLES) : 1;
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(MAX_DRAW_CYCLES - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   line_cmd_t        r_cmd;
   logic             r_grant_id;
   logic             r_ptr;
   logic [1:0]       r_ack;
   logic [CNT_W-1:0] r_cnt;

   logic             w_winner;
   logic             w_arb_valid;
   logic             w_grant;
   logic             w_limit;
   logic             w_in_go;

   rr_arb2 u_rr_arb2 (
      .i_req    (i_req),
      .i_ptr    (r_ptr),
      .o_winner (w_winner),
      .o_valid  (w_arb_valid)
   );

   assign w_in_go = (r_state == GO);
   assign w_grant = (r_state == IDLE) && w_arb_valid;
   assign w_limit = (r_cnt == C_CNT_LAST);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_arb_valid) begin
               w_state_nxt = GO;
            end
         end
         GO: begin
            if (i_done || w_limit) begin
               w_state_nxt = RELEASE;
            end
         end
         RELEASE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Command, owner and pointer only change on a grant, so the engine sees
   // stable fields for the whole draw.
   always_ff @(posedge clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_cmd      <= '0;
         r_grant_id <= 1'b0;
         r_ptr      <= 1'b0;
         r_ack      <= 2'b00;
      end else begin
         r_ack <= 2'b00;
         if (w_grant) begin
            r_cmd      <= w_winner ? i_cmd1 : i_cmd0;
            r_grant_id <= w_winner;
            r_ptr      <= ~w_winner;
            r_ack      <= w_winner ? 2'b10 : 2'b01;
         end
      end
   end

   always_ff @(posedge clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_cnt <= '0;
      end else if (w_grant) begin
         r_cnt <= '0;
      end else if (w_in_go && !w_limit) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_ack      = r_ack;
   assign o_grant_id = r_grant_id;
   assign o_busy     = (r_state != IDLE);
   assign o_go       = w_in_go;
   // A completion landing on the last allowed cycle wins over the watchdog.
   assign o_timeout  = w_in_go && w_limit && !i_done;
   assign o_colour   = r_cmd.colour;
   assign o_X0       = r_cmd.x0;
   assign o_Y0       = r_cmd.y0;
   assign o_X1       = r_cmd.x1;
   assign o_Y1       = r_cmd.y1;

endmodule

`default_nettype wire

// File: tb/tb_line_draw_arbiter.sv
// ============================================================================
// tb_line_draw_arbiter -- scoreboard bench: grants, fields, draw length, timeout
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_line_draw_arbiter;
   import line_pkg::*;

   localparam int MAXC = 16;

   typedef struct packed {
      logic      id;
      line_cmd_t cmd;
   } exp_t;

   typedef struct {
      int len;
      int to;
   } res_t;

   logic        clock;
   logic        i_reset_n;
   logic [1:0]  i_req;
   line_cmd_t   i_cmd0;
   line_cmd_t   i_cmd1;
   logic [1:0]  o_ack;
   logic        o_grant_id;
   logic        o_busy;
   logic        o_go;
   logic        i_done;
   logic [2:0]  o_colour;
   logic [8:0]  o_X0;
   logic [7:0]  o_Y0;
   logic [8:0]  o_X1;
   logic [7:0]  o_Y1;
   logic        o_timeout;

   int          checks;
   int          failures;
   exp_t        exp_q[$];
   res_t        res_q[$];
   logic [1:0]  held;
   line_cmd_t   cmd_v[2];
   logic        ptr_m;

   line_draw_arbiter #(.MAX_DRAW_CYCLES(MAXC)) dut (
      .clock      (clock),
      .i_reset_n  (i_reset_n),
      .i_req      (i_req),
      .i_cmd0     (i_cmd0),
      .i_cmd1     (i_cmd1),
      .o_ack      (o_ack),
      .o_grant_id (o_grant_id),
      .o_busy     (o_busy),
      .o_go       (o_go),
      .i_done     (i_done),
      .o_colour   (o_colour),
      .o_X0       (o_X0),
      .o_Y0       (o_Y0),
      .o_X1       (o_X1),
      .o_Y1       (o_Y1),
      .o_timeout  (o_timeout)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_go"},      o_go,      0);
      chk({tag, "_ack"},     o_ack,     0);
      chk({tag, "_busy"},    o_busy,    0);
      chk({tag, "_timeout"}, o_timeout, 0);
      chk({tag, "_grant"},   o_grant_id, 0);
      chk({tag, "_fields"},  {o_colour, o_Y1, o_X1, o_Y0, o_X0}, 0);
   endtask

   function automatic line_cmd_t rand_cmd();
      line_cmd_t c;
      c.colour = 3'($urandom);
      c.y1     = 8'($urandom);
      c.x1     = 9'($urandom);
      c.y0     = 8'($urandom);
      c.x0     = 9'($urandom);
      return c;
   endfunction

   task automatic drive();
      i_req  = held;
      i_cmd0 = cmd_v[0];
      i_cmd1 = cmd_v[1];
   endtask

   // Entered and left in an IDLE cycle, 1 time unit after the clock edge.
   // d = GO cycle (1-based) on which the engine reports done; d > MAXC means never.
   task automatic run_round(input logic [1:0] add, input int d, input bit rnd);
      logic w;
      int   n;
      for (int k = 0; k < 2; k++) begin
         if (add[k] && !held[k]) begin
            held[k] = 1'b1;
            if (rnd) cmd_v[k] = rand_cmd();
         end
      end
      drive();
      if (held == 2'b00) begin
         i_done = 1'($urandom_range(0, 1));
         @(posedge clock); #1;
         i_done = 1'b0;
         chk("idle_stays", o_busy, 0);
         return;
      end
      w     = (held == 2'b11) ? ptr_m : held[1];
      ptr_m = ~w;
      exp_q.push_back('{id: w, cmd: cmd_v[w]});
      res_q.push_back('{len: (d <= MAXC) ? d : MAXC, to: (d > MAXC) ? 1 : 0});
      n = 0;
      while (o_ack == 2'b00 && n < 8) begin
         @(posedge clock); #1;
         i_done = 1'b0;
         n++;
      end
      chk("ack_latency", n, 1);
      if (o_ack == 2'b00) return;
      held[w] = 1'b0;
      drive();
      for (int c = 1; c <= MAXC; c++) begin
         if (c == d) i_done = 1'b1;
         @(posedge clock); #1;
         i_done = 1'b0;
         if (c >= d) break;
      end
      chk("release_go", o_go, 0);
      chk("release_busy", o_busy, 1);
      i_done = 1'($urandom_range(0, 1));
      @(posedge clock); #1;
      chk("idle_busy", o_busy, 0);
      chk("idle_go", o_go, 0);
      i_done = 1'($urandom_range(0, 1));
   endtask

   // Monitor: pops expectations when the DUT acks and when a draw ends.
   initial begin : monitor
      exp_t      e;
      res_t      r;
      line_cmd_t cur;
      int        go_len;
      int        to_cnt;
      logic      prev_go;
      cur = '0; go_len = 0; to_cnt = 0; prev_go = 1'b0;
      forever begin
         @(negedge clock);
         if (!i_reset_n) begin
            prev_go = 1'b0; go_len = 0; to_cnt = 0;
         end else begin
            if (o_ack != 2'b00) begin
               if (exp_q.size() == 0) begin
                  chk("ack_unexpected", o_ack, 0);
               end else begin
                  e   = exp_q.pop_front();
                  cur = e.cmd;
                  chk("ack_vector", o_ack, (e.id ? 2'b10 : 2'b01));
                  chk("grant_id", o_grant_id, e.id);
                  chk("ack_go", o_go, 1);
                  chk("ack_fields", {o_colour, o_Y1, o_X1, o_Y0, o_X0}, e.cmd);
               end
               chk("ack_first_cycle", go_len, 0);
            end
            if (o_go) begin
               go_len++;
               if (o_timeout) to_cnt++;
               chk("fields_stable", {o_colour, o_Y1, o_X1, o_Y0, o_X0}, cur);
            end else begin
               chk("timeout_outside_go", o_timeout, 0);
            end
            if (prev_go && !o_go) begin
               if (res_q.size() == 0) begin
                  chk("draw_end_unexpected", go_len, 0);
               end else begin
                  r = res_q.pop_front();
                  chk("go_length", go_len, r.len);
                  chk("timeout_pulses", to_cnt, r.to);
               end
               go_len = 0; to_cnt = 0;
            end
            prev_go = o_go;
         end
      end
   end

   initial begin : global_guard
      #500000;
      $display("FAIL global_timeout: simulation did not finish, got running expected done");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

   initial begin : stimulus
      checks = 0; failures = 0;
      held = 2'b00; ptr_m = 1'b0;
      cmd_v[0] = '0; cmd_v[1] = '0;
      i_reset_n = 1'b0; i_done = 1'b0;
      drive();
      repeat (3) @(posedge clock);
      #1;
      chk_zero("reset");
      i_reset_n = 1'b1;
      @(posedge clock); #1;

      // Contention: 0, then 1, then 0 again, then drain 1.
      run_round(2'b11, 2, 1'b1);
      run_round(2'b00, 3, 1'b1);
      run_round(2'b11, 1, 1'b1);
      run_round(2'b00, 4, 1'b1);

      // Single request with known fields.
      cmd_v[0] = {3'd5, 8'd10, 9'd20, 8'd1, 9'd2};
      run_round(2'b01, 3, 1'b0);

      // Watchdog, exact boundary, one short of the boundary.
      run_round(2'b10, MAXC + 5, 1'b1);
      run_round(2'b01, MAXC, 1'b1);
      run_round(2'b10, MAXC - 1, 1'b1);

      // Reset in the middle of a draw.
      held = 2'b01;
      cmd_v[0] = rand_cmd();
      drive();
      exp_q.push_back('{id: 1'b0, cmd: cmd_v[0]});
      begin
         int n;
         n = 0;
         while (o_ack == 2'b00 && n < 8) begin
            @(posedge clock); #1;
            n++;
         end
         chk("rst_mid_ack", n, 1);
      end
      held = 2'b00;
      drive();
      repeat (4) @(posedge clock);
      #1;
      chk("rst_mid_go_before", o_go, 1);
      i_reset_n = 1'b0;
      #1;
      chk_zero("rst_mid");
      ptr_m = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      chk_zero("rst_mid_hold");
      i_reset_n = 1'b1;
      run_round(2'b10, 3, 1'b1);
      run_round(2'b11, 2, 1'b1);
      run_round(2'b00, 2, 1'b1);

      for (int i = 0; i < 80; i++) begin
         run_round(2'($urandom_range(0, 3)), $urandom_range(1, MAXC + 4), 1'b1);
      end
      run_round(2'b00, 2, 1'b1);
      run_round(2'b00, 2, 1'b1);

      repeat (3) @(posedge clock);
      #1;
      chk("exp_queue_drained", exp_q.size(), 0);
      chk("res_queue_drained", res_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
